// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// Module   : md_if
// Brief    : Operand/result bundle between the datapath and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [WIDTH-1:0]      r_a_raw;
    logic [WIDTH-1:0]      r_mcand;
    logic [2*WIDTH-1:0]    r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic                  r_done;

    logic                  w_signed_op;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_rem_sh;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_sub;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH-1:0]      w_quot;
    logic [WIDTH-1:0]      w_rem;
    logic [WIDTH-1:0]      w_hi_fix;
    logic [WIDTH-1:0]      w_lo_fix;

    // op[0]=0 selects the signed variants (MULT/DIV); magnitudes are used in RUN
    assign w_signed_op = ~bus.op[0];
    assign w_abs_a     = (w_signed_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_abs_b     = (w_signed_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == CNT_W'(WIDTH-1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One shift-add or restoring-divide step on the accumulator
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_mcand});
        w_sub      = w_rem_sh[WIDTH-1:0] - r_mcand;
        w_acc_next = r_acc;
        if (r_op[1]) begin
            if (w_ge) begin
                w_acc_next = {w_sub, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else if (r_acc[0]) begin
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    // Sign correction; divide-by-zero bypasses the iterative result
    always_comb begin
        w_prod   = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
        w_quot   = (r_sign_a ^ r_sign_b) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem    = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_mcand == '0) begin
                w_hi_fix = r_a_raw;
                w_lo_fix = '1;
            end else begin
                w_hi_fix = w_rem;
                w_lo_fix = w_quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_raw  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_sign_a <= w_signed_op & bus.a[WIDTH-1];
                        r_sign_b <= w_signed_op & bus.b[WIDTH-1];
                        r_a_raw  <= bus.a;
                        r_mcand  <= w_abs_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_cnt    <= '0;
                    end else begin
                        if (bus.mthi) r_hi <= bus.a;
                        if (bus.mtlo) r_lo <= bus.a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_hi   <= w_hi_fix;
                    r_lo   <= w_lo_fix;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Brief    : Self-checking bench for md_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_if #(.WIDTH(WIDTH)) bus ();

    md_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, returns {hi, lo}
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: begin p = sx * sy; return p; end
            2'd1: begin p = {32'd0, x} * {32'd0, y}; return p; end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'({32'd0, x}) / longint'({32'd0, y});
                    r = longint'({32'd0, x}) % longint'({32'd0, y});
                end
                p = {r[31:0], q[31:0]};
                return p;
            end
        endcase
    endfunction

    // Issue one operation; optionally poke start/mthi during busy or mtlo with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke_cycle, input logic mt_with_start,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        logic [63:0] exp;
        int cyc;
        exp = ref_md(o, x, y);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        bus.mtlo  = mt_with_start;
        @(negedge clk);
        bus.start = 1'b0; bus.mtlo = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (bus.done !== 1'b0) chk("done_while_busy", {31'd0, bus.done}, 32'd0);
            if (cyc == poke_cycle) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            bus.a = $urandom; bus.b = $urandom;
        end
        chk("busy_cycles", cyc, LAT);
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("hi", bus.hi, exp[63:32]);
        chk("lo", bus.lo, exp[31:0]);
        hi_o = bus.hi;
        lo_o = bus.lo;
        @(negedge clk);
        chk("done_clear", {31'd0, bus.done}, 32'd0);
        chk("hi_hold", bus.hi, exp[63:32]);
    endtask

    logic [31:0] h, l;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b0, h, l);
        chk("mult_hi", h, 32'hFFFF_FFFF);
        chk("mult_lo", l, 32'hFFFF_FFF1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, h, l);
        chk("multu_hi", h, 32'hFFFF_FFFE);
        chk("multu_lo", l, 32'h0000_0001);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, h, l);
        chk("div_hi", h, 32'hFFFF_FFFF);
        chk("div_lo", l, 32'hFFFF_FFFD);
        run_op(2'd3, 32'h14, 32'd0, 0, 1'b0, h, l);
        chk("divu0_hi", h, 32'h0000_0014);
        chk("divu0_lo", l, 32'hFFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, h, l);
        chk("divovf_hi", h, 32'd0);
        chk("divovf_lo", l, 32'h8000_0000);
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, 1'b0, h, l);
        chk("div0_hi", h, 32'hFFFF_FFF0);

        // start/mthi/mtlo pulsed mid-operation must be ignored
        run_op(2'd1, 32'd3, 32'd4, 5, 1'b0, h, l);
        chk("poke_hi", h, 32'd0);
        chk("poke_lo", l, 32'h0C);

        // Direct HI/LO writes in IDLE
        @(negedge clk);
        bus.mthi = 1'b1; bus.a = 32'h1234;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.a = 32'h5678;
        chk("mthi_hi", bus.hi, 32'h1234);
        chk("mthi_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h5678);
        chk("mtlo_hi", bus.hi, 32'h1234);
        chk("mtlo_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.a = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mtboth_hi", bus.hi, 32'hCAFE_F00D);
        chk("mtboth_lo", bus.lo, 32'hCAFE_F00D);

        // start wins over mtlo
        run_op(2'd1, 32'd6, 32'd7, 0, 1'b1, h, l);
        chk("start_mtlo_lo", l, 32'd42);

        // Reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                chk("midrst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        run_op(2'd3, 32'd100, 32'd7, 0, 1'b0, h, l);
        chk("divu_lo", l, 32'd14);
        chk("divu_hi", h, 32'd2);

        // Randomized operations against the model
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = 32'($urandom_range(0, 9));
            if (i % 7 == 3) ra = 32'h8000_0000;
            run_op(ro, ra, rb, 0, 1'b0, h, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
- Sits directly downstream of regfile: takes rd1 (rs) and rd2 (rt) as operands, executes MULT/MULTU/DIV/DIVU over multiple cycles, and holds results in HI/LO for MFHI/MFLO.
- Controller stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  operand rs (from regfile rd1); also the data for mthi/mtlo.
- b  input  WIDTH  operand rt (from regfile rd2).
- mthi  input  1  write a to HI.
- mtlo  input  1  write a to LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset, synchronous and active-high, at any time including mid-operation: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: wait for start.
  - RUN: exactly WIDTH iterations.
  - FIX: sign correction, then HI/LO write.
- IDLE with start=1 at edge k:
  - Latch op.
  - For signed ops (MULT/DIV), latch |a| and |b| plus both sign bits; for unsigned ops, latch a and b raw.
  - Clear the accumulator and counter; go to RUN. busy=1 from after edge k.
- RUN, one iteration per cycle:
  - Multiply: shift-add. Test the LSB of the multiplier, conditionally add the multiplicand into the upper half of the 2*WIDTH accumulator (with carry), shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract the divisor from rem, keep the result if non-negative, set the quotient LSB accordingly.
  - After the WIDTH-th iteration (edge k+WIDTH), go to FIX.
- FIX, at edge k+WIDTH+1:
  - Apply sign correction and write hi/lo.
  - Set done=1 for the following cycle only; busy=0; return to IDLE.
  - Total: busy high WIDTH+1 cycles (33 for WIDTH=32); results visible in the cycle done=1.
- Sign rules:
  - MULT: negate the 2*WIDTH product if sign(a)^sign(b).
  - DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - All arithmetic wraps modulo 2^WIDTH. Most-negative/-1 gives lo=0x80000000, hi=0.
- Divide by zero, all divide ops: lo=all ones, hi=a unchanged. Full latency still applies.
- start while busy: ignored. Operands are not re-sampled.
- mthi/mtlo in IDLE (and start=0): hi<=a and/or lo<=a at the next edge. Both may be asserted together. done is not asserted.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins; mthi/mtlo are ignored.
- hi/lo hold their values at all other times. Operands a/b may change freely after the start edge.
- done is never asserted while busy=1 or during reset.

Test Plan:
- Reset, then MULT with a=0xFFFFFFFD, b=0x00000005 -> busy for 33 cycles, done one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with a=0x14, b=0 -> lo=0xFFFFFFFF, hi=0x00000014. Also DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Pulse start with new operands and mthi=1 at cycle 5 of a busy MULTU 3*4 -> result stays hi=0, lo=0x0C; timing unchanged; hi is not overwritten.
- mthi with a=0x1234 then mtlo with a=0x5678 in IDLE -> hi=0x1234, lo=0x5678 next cycle, done=0. Then start and mtlo together -> only the operation executes.
- Assert reset at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0. A following DIVU 100/7 completes normally with lo=14, hi=2.
